// File: rtl/ecc_encoder.sv
// ecc_encoder: write-side page ECC generator.
// Takes one 128-bit page as 8 words and accumulates an 8-bit position-XOR
// Hamming code as the words arrive (no page buffer). It also forwards the data
// stream delayed by one cycle, so the last word and its page code leave together.
// Optional feature macro: ECC_ENCODER_BATCH_CHECK_EN (checks in_batch against the
// internal word counter, sets a sticky seq_err, and suppresses code_vld for a bad page).
module ecc_encoder #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_batch,
  input  logic              end_of_page,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_batch,
  output logic [7:0]        code,
  output logic              code_vld,
  output logic              seq_err
);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t     state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] acc, acc_d;
  logic [7:0] code_d;
  logic       code_vld_d;
  logic [7:0] contrib;
  logic       close;

`ifdef ECC_ENCODER_BATCH_CHECK_EN
  logic       mismatch;
  logic       page_err, page_err_d;
  logic       seq_err_d;
`else
  logic       unused_batch;
  assign unused_batch = ^in_batch;
  assign seq_err      = 1'b0;
`endif

  // Code contribution of the current word: XOR of (bit position + 1) over set bits,
  // positioned by the internal word counter.
  always_comb begin
    contrib = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (in_data[j]) contrib = contrib ^ 8'(DATA_W * 32'(cnt) + j + 32'd1);
    end
  end

  // Next-state logic: accumulate words, close the page on word 7 or end_of_page.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    acc_d      = acc;
    code_d     = code;
    code_vld_d = 1'b0;
    close      = 1'b0;
    case (state)
      IDLE: begin
        if (in_vld) begin
          if (end_of_page) begin
            close = 1'b1;
          end else begin
            acc_d   = contrib;
            cnt_d   = 3'd1;
            state_d = ACCUM;
          end
        end else if (end_of_page) begin
          close = 1'b1;
        end
      end
      ACCUM: begin
        if (in_vld) begin
          if (cnt == 3'd7 || end_of_page) begin
            close = 1'b1;
          end else begin
            acc_d = acc ^ contrib;
            cnt_d = cnt + 3'd1;
          end
        end else if (end_of_page) begin
          close = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (close) begin
      code_d     = acc ^ (in_vld ? contrib : 8'h00);
      code_vld_d = 1'b1;
      acc_d      = '0;
      cnt_d      = '0;
      state_d    = IDLE;
    end
`ifdef ECC_ENCODER_BATCH_CHECK_EN
    // A page that saw any index mismatch still gets encoded, but is not announced.
    mismatch   = in_vld && (in_batch != cnt);
    seq_err_d  = seq_err | mismatch;
    page_err_d = page_err | mismatch;
    if (close) begin
      code_vld_d = ~(page_err | mismatch);
      page_err_d = 1'b0;
    end
`endif
  end

  // Encoder state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      code     <= '0;
      code_vld <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      acc      <= acc_d;
      code     <= code_d;
      code_vld <= code_vld_d;
    end
  end

  // One-cycle data pipeline; out_batch reports the counter position used for encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_batch <= '0;
    end else begin
      out_vld   <= in_vld;
      out_data  <= in_data;
      out_batch <= cnt;
    end
  end

`ifdef ECC_ENCODER_BATCH_CHECK_EN
  // Sticky sequence error and per-page error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err  <= 1'b0;
      page_err <= 1'b0;
    end else begin
      seq_err  <= seq_err_d;
      page_err <= page_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_encoder.sv
// tb_ecc_encoder: scoreboard bench for ecc_encoder with directed, hand-computed pages.
// Stimulus pushes expected data/code (with the cycle they must appear) into queues;
// a monitor pops and compares whenever out_vld or code_vld is seen.
module tb_ecc_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  in_batch = '0;
  logic        end_of_page = 1'b0;
  logic        out_vld;
  logic [15:0] out_data;
  logic [2:0]  out_batch;
  logic [7:0]  code;
  logic        code_vld;
  logic        seq_err;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] d;
    logic [2:0]  b;
  } dexp_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  c;
  } cexp_t;

  dexp_t dq[$];
  cexp_t cq[$];

  ecc_encoder #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .in_batch    (in_batch),
    .end_of_page (end_of_page),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_batch   (out_batch),
    .code        (code),
    .code_vld    (code_vld),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every presented output against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        checks++;
        $display("FAIL data_missing: got no out_vld expected data 0x%0h at cycle %0d", dq[0].d, dq[0].cyc);
        void'(dq.pop_front());
      end
      if (cq.size() > 0 && cq[0].cyc < cyc) begin
        checks++;
        $display("FAIL code_missing: got no code_vld expected code 0x%0h at cycle %0d", cq[0].c, cq[0].cyc);
        void'(cq.pop_front());
      end
      if (out_vld) begin
        if (dq.size() == 0) begin
          checks++;
          $display("FAIL data_unexpected: got out_vld data 0x%0h expected none (cycle %0d)", out_data, cyc);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          checks++;
          if (e.cyc == cyc && e.d === out_data && e.b === out_batch) passes++;
          else $display("FAIL data: got d=0x%0h b=%0d cyc=%0d expected d=0x%0h b=%0d cyc=%0d",
                        out_data, out_batch, cyc, e.d, e.b, e.cyc);
        end
      end
      if (code_vld) begin
        if (cq.size() == 0) begin
          checks++;
          $display("FAIL code_unexpected: got code_vld code 0x%0h expected none (cycle %0d)", code, cyc);
        end else begin
          cexp_t e;
          e = cq.pop_front();
          checks++;
          if (e.cyc == cyc && e.c === code) passes++;
          else $display("FAIL code: got 0x%0h cyc=%0d expected 0x%0h cyc=%0d", code, cyc, e.c, e.cyc);
        end
      end
    end
  end

  // Drive one cycle; outputs of this cycle are due right after the capturing edge.
  task automatic put(input logic v, input logic [15:0] d, input logic [2:0] pos,
                     input logic [2:0] b, input logic e, input logic ce, input logic [7:0] c);
    dexp_t de;
    cexp_t cx;
    in_vld = v; in_data = d; in_batch = b; end_of_page = e;
    if (v) begin
      de.cyc = cyc + 1; de.d = d; de.b = pos;
      dq.push_back(de);
    end
    if (ce) begin
      cx.cyc = cyc + 1; cx.c = c;
      cq.push_back(cx);
    end
    @(posedge clk); #1;
    in_vld = 1'b0; end_of_page = 1'b0;
  endtask

  // Full 8-word page, end_of_page on word 7 only if eop7 is set.
  task automatic page8(input logic [127:0] p, input logic eop7, input logic [7:0] c);
    for (int i = 0; i < 8; i++) begin
      put(1'b1, p[16*i +: 16], 3'(i), 3'(i), (i == 7) && eop7, i == 7, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_vld"},   32'(out_vld),   32'h0);
    chk({tag, "_out_data"},  32'(out_data),  32'h0);
    chk({tag, "_out_batch"}, 32'(out_batch), 32'h0);
    chk({tag, "_code"},      32'(code),      32'h0);
    chk({tag, "_code_vld"},  32'(code_vld),  32'h0);
    chk({tag, "_seq_err"},   32'(seq_err),   32'h0);
  endtask

  initial begin
    #23;
    chk_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all-zero page
    page8(128'h0, 1'b1, 8'h00);
    idle(2);
    // 2: single set bits
    page8({112'h0, 16'h0001}, 1'b1, 8'h01);
    page8({96'h0, 16'h0001, 16'h0}, 1'b1, 8'h11);
    page8({16'h8000, 112'h0}, 1'b1, 8'h80);
    idle(1);
    // 3: all ones -> XOR(1..128)
    page8({128{1'b1}}, 1'b1, 8'h80);
    // mixed word 3 = 0x00A5 -> 49^51^54^56
    page8({64'h0, 16'h00A5, 48'h0}, 1'b1, 8'h0C);
    // word 7 closes the page without end_of_page: g=112 -> 113
    page8({16'h0001, 112'h0}, 1'b0, 8'h71);
    idle(1);
    // 4: short page closed on word 0, then empty page
    put(1'b1, 16'h0003, 3'd0, 3'd0, 1'b1, 1'b1, 8'h03);
    idle(1);
    put(1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 8'h00);
    idle(1);
    // short page closed by end_of_page without data: word 2 bit 4 -> 37
    put(1'b1, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 8'h0);
    put(1'b1, 16'h0000, 3'd1, 3'd1, 1'b0, 1'b0, 8'h0);
    put(1'b1, 16'h0010, 3'd2, 3'd2, 1'b0, 1'b0, 8'h0);
    put(1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 8'h25);
    idle(1);
    // 5: back-to-back pages, no bubble
    page8({112'h0, 16'h0001}, 1'b1, 8'h01);
    page8({16'h8000, 112'h0}, 1'b1, 8'h80);
    idle(2);
    chk("code_held", 32'(code), 32'h80);

    // 6: reset mid-page after word 3, then a clean zero page
    for (int i = 0; i < 4; i++) put(1'b1, 16'hFFFF, 3'(i), 3'(i), 1'b0, 1'b0, 8'h0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    page8(128'h0, 1'b1, 8'h00);
    idle(2);
    chk("seq_err_clean", 32'(seq_err), 32'h0);

`ifdef ECC_ENCODER_BATCH_CHECK_EN
    // Wrong in_batch at cnt 2: page encoded but not announced, seq_err sticks.
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 16'h0001, 3'(i), (i == 2) ? 3'd5 : 3'(i), i == 7, 1'b0, 8'h0);
    end
    idle(2);
    chk("seq_err_set", 32'(seq_err), 32'h1);
    page8({112'h0, 16'h0001}, 1'b1, 8'h01);
    idle(2);
    chk("seq_err_sticky", 32'(seq_err), 32'h1);
`endif

    idle(3);
    chk("data_queue_drained", 32'(dq.size()), 32'h0);
    chk("code_queue_drained", 32'(cq.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
